// File: rtl/sc_bitstream_counter_if.sv
// -----------------------------------------------------------------------------
// sc_bitstream_counter_if
//
// Groups the control, bitstream and result signals of the stochastic-to-binary
// decoder so that the upstream bitstream generator (or a bench) and the decoder
// connect through a single bundle.
//
// Signals
//   start        begin a window (honoured only while idle)
//   continuous   at window completion, roll straight into the next window
//   abort        drop the current window without producing a result
//   bit_in       stochastic bitstream sample
//   bit_valid    bit_in carries a sample this cycle
//   busy         decoder is accumulating a window
//   result       ones count of the last completed window (0..2^WINDOW_LOG2)
//   result_valid one-cycle pulse when result updates
//
// Modports
//   master  drives the control/bitstream side, observes the result side
//   slave   the decoder itself
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface sc_bitstream_counter_if #(
    parameter int WINDOW_LOG2 = 8
);
    logic                 start;
    logic                 continuous;
    logic                 abort;
    logic                 bit_in;
    logic                 bit_valid;
    logic                 busy;
    logic [WINDOW_LOG2:0] result;
    logic                 result_valid;

    modport master (
        output start,
        output continuous,
        output abort,
        output bit_in,
        output bit_valid,
        input  busy,
        input  result,
        input  result_valid
    );

    modport slave (
        input  start,
        input  continuous,
        input  abort,
        input  bit_in,
        input  bit_valid,
        output busy,
        output result,
        output result_valid
    );
endinterface

// File: rtl/sc_bitstream_counter.sv
// -----------------------------------------------------------------------------
// sc_bitstream_counter
//
// Stochastic-to-binary decoder. Counts the ones of a unipolar stochastic
// bitstream over a window of 2^WINDOW_LOG2 valid samples and presents the
// count as a binary result with a one-cycle valid pulse. Supports single-shot
// windows and continuous back-to-back windows with no gap cycle.
//
// Ports
//   clk    system clock, all logic on the rising edge
//   rst_n  synchronous reset, ACTIVE HIGH despite its name (1 = reset)
//   bus    sc_bitstream_counter_if.slave
//            in : start, continuous, abort, bit_in, bit_valid
//            out: busy, result[WINDOW_LOG2:0], result_valid
//
// Parameters
//   WINDOW_LOG2  log2 of the window length in valid samples (2..16)
//
// Timing (bit_valid held high, start in cycle 0)
//   samples are taken in cycles 1..2^WINDOW_LOG2, result_valid pulses in
//   cycle 2^WINDOW_LOG2+1 with the registered count.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sc_bitstream_counter #(
    parameter int WINDOW_LOG2 = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sc_bitstream_counter_if.slave   bus
);

    // Ones counter and result carry one extra bit so an all-ones window
    // reads exactly 2^WINDOW_LOG2 instead of wrapping to zero.
    localparam int CNT_W = WINDOW_LOG2 + 1;

    localparam logic [WINDOW_LOG2-1:0] SAMPLE_LAST = '1;
    localparam logic [WINDOW_LOG2-1:0] SAMPLE_ONE  = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;

    logic [WINDOW_LOG2-1:0]  sample_cnt;
    logic [CNT_W-1:0]        ones_cnt;

    logic                    clr_p0;
    logic                    acc_p0;
    logic                    done_p0;
    logic                    last_sample_p0;
    logic [CNT_W-1:0]        window_total_p0;

    logic [CNT_W-1:0]        result_p1;
    logic                    vld_p1;

    // Zero-extend a single stochastic bit and add it to a running count.
    function automatic logic [CNT_W-1:0] add_bit(
        input logic [CNT_W-1:0] acc,
        input logic             b
    );
        return acc + {{WINDOW_LOG2{1'b0}}, b};
    endfunction

    // Sample counter advance; wraps to zero naturally after SAMPLE_LAST,
    // although completion clears it explicitly anyway.
    function automatic logic [WINDOW_LOG2-1:0] next_sample(
        input logic [WINDOW_LOG2-1:0] cnt
    );
        return cnt + SAMPLE_ONE;
    endfunction

    // ---- stage p0: window bookkeeping and completion decision ----
    assign last_sample_p0  = (sample_cnt == SAMPLE_LAST);
    // The completing sample itself is part of the window, so it is folded in
    // here rather than waiting one more cycle for ones_cnt to catch up.
    assign window_total_p0 = add_bit(ones_cnt, bus.bit_in);

    always_comb begin
        state_d = state_q;
        clr_p0  = 1'b0;
        acc_p0  = 1'b0;
        done_p0 = 1'b0;

        case (state_q)
            IDLE: begin
                // abort in idle blocks a simultaneous start; bit_in during
                // the start cycle is never sampled.
                if (bus.start && !bus.abort) begin
                    state_d = ACCUM;
                    clr_p0  = 1'b1;
                end
            end

            ACCUM: begin
                // abort outranks a completing sample: no result, no pulse.
                if (bus.abort) begin
                    state_d = IDLE;
                    clr_p0  = 1'b1;
                end else if (bus.bit_valid) begin
                    if (last_sample_p0) begin
                        done_p0 = 1'b1;
                        clr_p0  = 1'b1;
                        // Only the level of continuous in the completion
                        // cycle decides whether the next window follows.
                        state_d = bus.continuous ? ACCUM : IDLE;
                    end else begin
                        acc_p0 = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                clr_p0  = 1'b1;
            end
        endcase
    end

    // ---- stage p1: registered state, counters and result ----
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= IDLE;
            sample_cnt <= '0;
            ones_cnt   <= '0;
            result_p1  <= '0;
            vld_p1     <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_p1  <= done_p0;

            if (clr_p0) begin
                sample_cnt <= '0;
                ones_cnt   <= '0;
            end else if (acc_p0) begin
                sample_cnt <= next_sample(sample_cnt);
                ones_cnt   <= window_total_p0;
            end

            // result only moves on completion; start/abort leave it alone.
            if (done_p0) begin
                result_p1 <= window_total_p0;
            end
        end
    end

    assign bus.busy         = (state_q == ACCUM);
    assign bus.result       = result_p1;
    assign bus.result_valid = vld_p1;

endmodule

// File: tb/tb_sc_bitstream_counter.sv
`timescale 1ns/1ps

module tb_sc_bitstream_counter;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sc_bitstream_counter_if #(.WINDOW_LOG2(4)) bus4 ();
    sc_bitstream_counter_if #(.WINDOW_LOG2(8)) bus8 ();

    sc_bitstream_counter #(.WINDOW_LOG2(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    sc_bitstream_counter #(.WINDOW_LOG2(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] bits;     // bit_in for valid sample k is bits[k]
        int          gap;      // invalid cycles after each valid sample
        logic        invbit;   // bit_in driven on invalid cycles
        logic        restart;  // re-pulse start mid-window
        int          exp_res;
        int          exp_lat;  // cycle of result_valid, start = cycle 0
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle4();
        bus4.start      = 1'b0;
        bus4.continuous = 1'b0;
        bus4.abort      = 1'b0;
        bus4.bit_in     = 1'b0;
        bus4.bit_valid  = 1'b0;
    endtask

    task automatic idle8();
        bus8.start      = 1'b0;
        bus8.continuous = 1'b0;
        bus8.abort      = 1'b0;
        bus8.bit_in     = 1'b0;
        bus8.bit_valid  = 1'b0;
    endtask

    // Single-shot window on the 16-sample instance; observes outputs in each
    // cycle c and then drives inputs for that same cycle.
    task automatic run_window(input vec_t v, output int pulse_cyc, output int busy_cnt,
                              output int pulses, output int res);
        int k;
        int phase;
        k = 0; phase = 0;
        pulse_cyc = -1; busy_cnt = 0; pulses = 0; res = -1;
        bus4.start = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (bus4.busy) busy_cnt++;
            if (bus4.result_valid) begin
                pulses++;
                pulse_cyc = c;
                res = int'(bus4.result);
            end
            bus4.start = v.restart && (c == 5);
            if (k < 16 && phase == 0) begin
                bus4.bit_valid = 1'b1;
                bus4.bit_in    = v.bits[k];
                k++;
                phase = v.gap;
            end else begin
                bus4.bit_valid = 1'b0;
                bus4.bit_in    = v.invbit;
                if (phase > 0) phase--;
            end
        end
        idle4();
    endtask

    initial begin
        int pc, bc, np, rs;
        int pcyc [4];
        int pval [4];
        logic [30:0] lfsr;
        int exp_pop;
        int last_valid;
        int k;

        vecs[0] = '{bits: 16'hFFFF, gap: 0, invbit: 1'b0, restart: 1'b0, exp_res: 16, exp_lat: 17};
        vecs[1] = '{bits: 16'h5555, gap: 0, invbit: 1'b0, restart: 1'b0, exp_res: 8,  exp_lat: 17};
        vecs[2] = '{bits: 16'h0000, gap: 0, invbit: 1'b1, restart: 1'b0, exp_res: 0,  exp_lat: 17};
        vecs[3] = '{bits: 16'hFFFF, gap: 1, invbit: 1'b1, restart: 1'b1, exp_res: 16, exp_lat: 32};
        vecs[4] = '{bits: 16'h8001, gap: 2, invbit: 1'b1, restart: 1'b0, exp_res: 2,  exp_lat: 47};

        idle4();
        idle8();
        rst_n = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();

        chk("reset_busy", int'(bus4.busy), 0);
        chk("reset_result", int'(bus4.result), 0);
        chk("reset_result_valid", int'(bus4.result_valid), 0);
        chk("reset_result_w8", int'(bus8.result), 0);

        // Table-driven single-shot windows
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("row%0d_result_held", i), int'(bus4.result),
                (i == 0) ? 0 : vecs[i-1].exp_res);
            run_window(vecs[i], pc, bc, np, rs);
            chk($sformatf("row%0d_pulses", i), np, 1);
            chk($sformatf("row%0d_pulse_cycle", i), pc, vecs[i].exp_lat);
            chk($sformatf("row%0d_result", i), rs, vecs[i].exp_res);
            chk($sformatf("row%0d_busy_cycles", i), bc, vecs[i].exp_lat - 1);
            chk($sformatf("row%0d_busy_after", i), int'(bus4.busy), 0);
            repeat (3) tick();
        end

        // Abort at sample 10
        np = 0;
        bus4.start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (bus4.result_valid) np++;
            if (c == 10) chk("abort10_busy_before", int'(bus4.busy), 1);
            if (c == 11) chk("abort10_busy_after", int'(bus4.busy), 0);
            bus4.start     = 1'b0;
            bus4.bit_valid = 1'b1;
            bus4.bit_in    = 1'b1;
            bus4.abort     = (c == 10);
        end
        idle4();
        chk("abort10_no_pulse", np, 0);
        chk("abort10_result_kept", int'(bus4.result), 2);
        repeat (2) tick();

        // Abort coincident with the 16th (completing) sample
        np = 0;
        bus4.start = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (bus4.result_valid) np++;
            if (c == 17) chk("abort16_busy_after", int'(bus4.busy), 0);
            bus4.start     = 1'b0;
            bus4.bit_valid = (c <= 16);
            bus4.bit_in    = 1'b1;
            bus4.abort     = (c == 16);
        end
        idle4();
        chk("abort16_no_pulse", np, 0);
        chk("abort16_result_kept", int'(bus4.result), 2);

        // abort in IDLE blocks a simultaneous start
        bus4.start = 1'b1;
        bus4.abort = 1'b1;
        tick();
        idle4();
        chk("idle_abort_blocks_start", int'(bus4.busy), 0);
        tick();
        chk("idle_abort_stays_idle", int'(bus4.busy), 0);

        // Reset at sample 7
        bus4.start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            bus4.start     = 1'b0;
            bus4.bit_valid = 1'b1;
            bus4.bit_in    = 1'b1;
            rst_n          = (c == 7);
        end
        tick();
        rst_n = 1'b0;
        idle4();
        chk("rst7_busy", int'(bus4.busy), 0);
        chk("rst7_result", int'(bus4.result), 0);
        chk("rst7_result_valid", int'(bus4.result_valid), 0);
        repeat (2) tick();

        // Continuous: 16 ones then zeros, continuous dropped during window 3
        np = 0;
        for (int i = 0; i < 4; i++) begin pcyc[i] = -1; pval[i] = -1; end
        bus4.start      = 1'b1;
        bus4.continuous = 1'b1;
        for (int c = 1; c <= 55; c++) begin
            tick();
            if (bus4.result_valid) begin
                if (np < 4) begin
                    pcyc[np] = c;
                    pval[np] = int'(bus4.result);
                end
                np++;
            end
            if (c == 17) chk("cont_busy_c17", int'(bus4.busy), 1);
            if (c == 33) chk("cont_busy_c33", int'(bus4.busy), 1);
            if (c == 49) chk("cont_busy_c49", int'(bus4.busy), 0);
            bus4.start      = 1'b0;
            bus4.bit_valid  = (c <= 48);
            bus4.bit_in     = (c <= 16);
            bus4.continuous = (c < 40);
        end
        idle4();
        chk("cont_pulses", np, 3);
        chk("cont_p0_cycle", pcyc[0], 17);
        chk("cont_p0_result", pval[0], 16);
        chk("cont_p1_cycle", pcyc[1], 33);
        chk("cont_p1_result", pval[1], 0);
        chk("cont_p2_cycle", pcyc[2], 49);
        chk("cont_p2_result", pval[2], 0);

        // LFSR stream into the 256-sample instance, with invalid gap cycles
        lfsr = 31'd1;
        exp_pop = 0;
        last_valid = -1;
        k = 0;
        np = 0; pc = -1; rs = -1;
        bus8.start = 1'b1;
        for (int c = 1; c <= 700; c++) begin
            tick();
            if (bus8.result_valid) begin
                np++;
                pc = c;
                rs = int'(bus8.result);
            end
            bus8.start = 1'b0;
            if (k < 256 && (c % 5) != 0) begin
                bus8.bit_valid = 1'b1;
                bus8.bit_in    = lfsr[30];
                exp_pop += int'(lfsr[30]);
                lfsr = {lfsr[29:0], lfsr[30] ^ lfsr[27]};
                k++;
                last_valid = c;
            end else begin
                bus8.bit_valid = 1'b0;
                bus8.bit_in    = 1'b1;
            end
        end
        idle8();
        chk("lfsr_pulses", np, 1);
        chk("lfsr_pulse_cycle", pc, last_valid + 1);
        chk("lfsr_popcount", rs, exp_pop);
        chk("lfsr_busy_after", int'(bus8.busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
